keypad_hit_scanner: RTL and testbench

Upstream stage of the Mole top. It scans a 4x4 matrix keypad and synchronises and debounces the 16 keys. Each new key press becomes a single-cycle one-hot pulse that drives Mole's Hit_point[15:0]. The block also exposes the encoded key, a valid strobe and the debounced key map.

---
 rtl/mole_pkg.sv | 13 +
 rtl/hit_frame_debounce.sv | 53 +++++
 rtl/keypad_hit_scanner.sv | 60 ++++++
 tb/tb_keypad_hit_scanner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: shared key-map sizes and the lowest-set-bit index helper for the Mole keypad path
package mole_pkg;
  localparam int NUM_KEYS = 16;
  localparam int KEY_W = 4;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCORE_W = 10;
  typedef logic [NUM_KEYS-1:0] key_map_t;
  function automatic logic [KEY_W-1:0] lsb_index(input key_map_t v);
    lsb_index = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (v[i]) lsb_index = KEY_W'(i);
  endfunction
endpackage

// File: rtl/hit_frame_debounce.sv
// hit_frame_debounce: frame-level debounce of the key map and single-pulse new-press reporting
module hit_frame_debounce
  import mole_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_end,
  input  logic             enable,
  input  key_map_t         s,
  output key_map_t         pressed,
  output key_map_t         hit_point,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid
);
  localparam logic [3:0] D = 4'(DEBOUNCE_FRAMES);
  key_map_t last_frame, fresh;
  logic [3:0] match_cnt, cnt_next;
  logic settle;
  // next match count saturates at D; any change in the snapshot restarts the run at 1
  always_comb begin
    cnt_next = (s == last_frame) ? ((match_cnt == D) ? D : match_cnt + 4'd1) : 4'd1;
    settle = cnt_next == D;
    fresh = s & ~pressed;
  end
  // debounced map commits on a settled frame; only the lowest newly pressed key pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_frame <= '0;
      match_cnt <= '0;
      pressed <= '0;
      hit_point <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
    end else begin
      hit_point <= '0;
      key_valid <= 1'b0;
      if (frame_end) begin
        last_frame <= s;
        match_cnt <= cnt_next;
        if (settle) begin
          pressed <= s;
          if (enable && |fresh) begin
            hit_point <= fresh & (-fresh);
            key_code <= lsb_index(fresh);
            key_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/keypad_hit_scanner.sv
// keypad_hit_scanner: 4x4 keypad row scanner with column sync, frame assembly and debounced hit pulses
module keypad_hit_scanner
  import mole_pkg::*;
#(
  parameter int SCAN_TICKS = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                Clk,
  input  logic                Set,
  input  logic                Enable,
  input  logic [COLS-1:0]     Col_in,
  output logic [ROWS-1:0]     Row_drive,
  output logic [NUM_KEYS-1:0] Hit_point,
  output logic [KEY_W-1:0]    Key_code,
  output logic                Key_valid,
  output logic [NUM_KEYS-1:0] Pressed
);
  logic [COLS-1:0] sync1, sync2;
  logic [7:0] tick;
  logic [1:0] row, row_next;
  logic wrap, frame_end;
  logic [NUM_KEYS-COLS-1:0] acc;
  key_map_t snap;
  // row 3 is taken straight from the live sample so the frame closes on its own sampling edge
  always_comb begin
    wrap = tick == 8'(SCAN_TICKS - 1);
    row_next = wrap ? row + 2'd1 : row;
    frame_end = wrap && row == 2'd3;
    snap = {~sync2, acc};
  end
  // column synchroniser, scan counter, row drive and per-row accumulation
  always_ff @(posedge Clk or posedge Set) begin
    if (Set) begin
      sync1 <= '1;
      sync2 <= '1;
      tick <= '0;
      row <= '0;
      Row_drive <= 4'b1110;
      acc <= '0;
    end else begin
      sync1 <= Col_in;
      sync2 <= sync1;
      tick <= wrap ? 8'd0 : tick + 8'd1;
      row <= row_next;
      Row_drive <= ~(4'b0001 << row_next);
      for (int r = 0; r < ROWS - 1; r++) if (wrap && row == 2'(r)) acc[r*COLS +: COLS] <= ~sync2;
    end
  end
  hit_frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk(Clk),
    .rst(Set),
    .frame_end(frame_end),
    .enable(Enable),
    .s(snap),
    .pressed(Pressed),
    .hit_point(Hit_point),
    .key_code(Key_code),
    .key_valid(Key_valid)
  );
endmodule

// File: tb/tb_keypad_hit_scanner.sv
// tb_keypad_hit_scanner: ideal keypad model driving the scanner, checked against a frame-level debounce model
module tb_keypad_hit_scanner;
  localparam int D = 3;
  localparam int FR = 16;
  logic Clk = 1'b0, Set = 1'b0, Enable = 1'b1;
  logic [3:0] Col_in, Row_drive, Key_code;
  logic [15:0] Hit_point, Pressed;
  logic Key_valid;
  int checks = 0, failures = 0, cyc = 0, pulses = 0, last_cyc = 0, p0 = 0, sc = 0;
  logic [15:0] keys = '0, pm = '0, eh = '0, last_hit = '0;
  logic [3:0] ec = '0, last_code = '0;
  logic ev = 1'b0;
  bit model_on = 1'b1;
  logic [15:0] hist[$];

  keypad_hit_scanner #(.SCAN_TICKS(4), .DEBOUNCE_FRAMES(D)) dut (
    .Clk(Clk), .Set(Set), .Enable(Enable), .Col_in(Col_in), .Row_drive(Row_drive),
    .Hit_point(Hit_point), .Key_code(Key_code), .Key_valid(Key_valid), .Pressed(Pressed)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    Col_in = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !Row_drive[r]) Col_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [15:0] n;
    logic [3:0] er;
    bit stable;
    @(posedge Clk);
    #1;
    cyc++;
    if (Hit_point != 0) begin
      pulses++;
      last_hit = Hit_point;
      last_code = Key_code;
      last_cyc = cyc;
    end
    eh = '0;
    ev = 1'b0;
    if (cyc % FR == 0) begin
      hist.push_back(keys);
      if (hist.size() > D) void'(hist.pop_front());
      stable = hist.size() == D;
      foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
      if (stable) begin
        n = keys & ~pm;
        pm = keys;
        if (Enable)
          for (int i = 0; i < 16; i++)
            if (n[i] && !ev) begin
              eh = 16'h0001 << i;
              ec = 4'(i);
              ev = 1'b1;
            end
      end
    end
    if (model_on) begin
      chk("hit", Hit_point, eh);
      chk("valid", 16'(Key_valid), 16'(ev));
      chk("code", 16'(Key_code), 16'(ec));
      chk("pressed", Pressed, pm);
    end
    er = ~(4'b0001 << ((cyc / 4) % 4));
    chk("row", 16'(Row_drive), 16'(er));
  endtask

  task automatic run_frames(input int nf);
    for (int f = 0; f < nf; f++) begin
      cycle();
      while (cyc % FR != 0) cycle();
    end
  endtask

  task automatic do_reset(input int ncyc);
    #3 Set = 1'b1;
    #1;
    chk("rst_row", 16'(Row_drive), 16'h000e);
    chk("rst_hit", Hit_point, 16'h0000);
    chk("rst_valid", 16'(Key_valid), 16'h0000);
    chk("rst_code", 16'(Key_code), 16'h0000);
    chk("rst_pressed", Pressed, 16'h0000);
    repeat (ncyc) @(posedge Clk);
    @(negedge Clk);
    Set = 1'b0;
    cyc = 0;
    hist.delete();
    pm = '0;
    eh = '0;
    ec = '0;
    ev = 1'b0;
  endtask

  initial begin
    keys = 16'h0004;
    do_reset(2);
    run_frames(3);
    chk("t2_cyc", 16'(cyc), 16'd48);
    chk("t2_hit", Hit_point, 16'h0004);
    chk("t2_code", 16'(Key_code), 16'd2);
    chk("t2_valid", 16'(Key_valid), 16'd1);
    cycle();
    chk("t2_clear", Hit_point, 16'h0000);
    p0 = pulses;
    run_frames(63);
    chk("t2_no_repeat", 16'(pulses - p0), 16'd0);
    chk("t2_pressed", Pressed, 16'h0004);

    keys = '0;
    run_frames(4);
    keys = 16'h0220;
    p0 = pulses;
    run_frames(3);
    chk("t4_hit", Hit_point, 16'h0020);
    chk("t4_code", 16'(Key_code), 16'd5);
    run_frames(2);
    chk("t4_pressed", Pressed, 16'h0220);
    chk("t4_one_pulse", 16'(pulses - p0), 16'd1);
    keys = '0;
    run_frames(4);
    chk("t4_release", Pressed, 16'h0000);
    chk("t4_no_pulse", 16'(pulses - p0), 16'd1);

    Enable = 1'b0;
    keys = 16'h0001;
    p0 = pulses;
    run_frames(4);
    chk("t5_pressed", Pressed, 16'h0001);
    Enable = 1'b1;
    run_frames(4);
    chk("t5_no_pulse", 16'(pulses - p0), 16'd0);
    keys = '0;
    run_frames(4);
    keys = 16'h0001;
    run_frames(3);
    chk("t5_hit", Hit_point, 16'h0001);
    chk("t5_count", 16'(pulses - p0), 16'd1);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 0) keys = 16'($urandom) & 16'($urandom) & 16'($urandom);
      Enable = $urandom_range(0, 3) != 0;
      run_frames($urandom_range(1, 5));
    end

    Enable = 1'b1;
    keys = '0;
    run_frames(4);
    chk("t3_idle", Pressed, 16'h0000);
    model_on = 1'b0;
    p0 = pulses;
    for (int t = 0; t < 40; t++) begin
      if (t % 5 == 0) keys[7] = ~keys[7];
      cycle();
    end
    keys = 16'h0080;
    sc = cyc;
    repeat (160) cycle();
    chk("t3_count", 16'(pulses - p0), 16'd1);
    chk("t3_hit", last_hit, 16'h0080);
    chk("t3_code", 16'(last_code), 16'd7);
    chk("t3_latency", 16'(last_cyc - sc >= 48), 16'd1);
    chk("t3_pressed", Pressed, 16'h0080);

    keys = 16'h0004;
    repeat (5) cycle();
    do_reset(3);
    model_on = 1'b1;
    run_frames(3);
    chk("t6_hit", Hit_point, 16'h0004);
    chk("t6_code", 16'(Key_code), 16'd2);
    cycle();
    chk("t6_clear", 16'(Key_valid), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
